// File: rtl/axi_master_arbiter.sv
// AXI master arbiter: round-robin AW/AR grants, W-order FIFO and
// B/R steering from the master-index bits of the returned ID.
module axi_master_arbiter #(
    parameter int M_WIDTH  = 2,
    parameter int M_ID     = 2,
    parameter int WQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [(1<<M_WIDTH)-1:0]   MASTER_WR_ADDR_VALID,
    input  logic [(1<<M_WIDTH)-1:0]   MASTER_RD_ADDR_VALID,
    input  logic                      BUS_WR_ADDR_VALID,
    input  logic                      BUS_WR_ADDR_READY,
    input  logic                      BUS_WR_DATA_VALID,
    input  logic                      BUS_WR_DATA_READY,
    input  logic                      BUS_WR_DATA_LAST,
    input  logic [M_ID+M_WIDTH-1:0]   BUS_WR_BACK_ID,
    input  logic                      BUS_RD_ADDR_VALID,
    input  logic                      BUS_RD_ADDR_READY,
    input  logic [M_ID+M_WIDTH-1:0]   BUS_RD_BACK_ID,
    output logic [M_WIDTH-1:0]        wr_addr_sel,
    output logic [M_WIDTH-1:0]        wr_data_sel,
    output logic [M_WIDTH-1:0]        wr_resp_sel,
    output logic [M_WIDTH-1:0]        rd_addr_sel,
    output logic [M_WIDTH-1:0]        rd_data_sel,
    output logic                      wr_data_gate,
    output logic                      wq_full
);

    localparam int N  = 1 << M_WIDTH;
    localparam int PW = $clog2(WQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {AW_IDLE, AW_GRANT} aw_state_e;
    typedef enum logic {AR_IDLE, AR_GRANT} ar_state_e;

    // First requester scanning upward from last+1, wrapping modulo N
    function automatic logic [M_WIDTH-1:0] rr_pick(
        input logic [N-1:0]       req,
        input logic [M_WIDTH-1:0] last
    );
        logic [M_WIDTH-1:0] idx;
        logic               found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = last + M_WIDTH'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    aw_state_e          aw_state_q, aw_state_d;
    ar_state_e          ar_state_q, ar_state_d;
    logic [M_WIDTH-1:0] wr_addr_sel_q, wr_addr_sel_d;
    logic [M_WIDTH-1:0] rd_addr_sel_q, rd_addr_sel_d;
    logic [M_WIDTH-1:0] aw_last_q, aw_last_d;
    logic [M_WIDTH-1:0] ar_last_q, ar_last_d;
    logic [M_WIDTH-1:0] wr_data_sel_q, wr_data_sel_d;
    logic [M_WIDTH-1:0] wq_mem_q [WQ_DEPTH];
    logic [PW-1:0]      wq_wptr_q, wq_wptr_d;
    logic [PW-1:0]      wq_rptr_q, wq_rptr_d;
    logic [CW-1:0]      wq_count_q, wq_count_d;
    logic [CW-1:0]      wq_remain;
    logic               wq_push;
    logic               wq_pop;

    always_comb begin
        aw_state_d    = aw_state_q;
        wr_addr_sel_d = wr_addr_sel_q;
        aw_last_d     = aw_last_q;
        wq_push       = 1'b0;
        unique case (aw_state_q)
            AW_IDLE: begin
                if (|MASTER_WR_ADDR_VALID && wq_count_q < CW'(WQ_DEPTH)) begin
                    aw_state_d    = AW_GRANT;
                    wr_addr_sel_d = rr_pick(MASTER_WR_ADDR_VALID, aw_last_q);
                end
            end
            AW_GRANT: begin
                if (BUS_WR_ADDR_VALID && BUS_WR_ADDR_READY) begin
                    aw_state_d = AW_IDLE;
                    aw_last_d  = wr_addr_sel_q;
                    wq_push    = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        ar_state_d    = ar_state_q;
        rd_addr_sel_d = rd_addr_sel_q;
        ar_last_d     = ar_last_q;
        unique case (ar_state_q)
            AR_IDLE: begin
                if (|MASTER_RD_ADDR_VALID) begin
                    ar_state_d    = AR_GRANT;
                    rd_addr_sel_d = rr_pick(MASTER_RD_ADDR_VALID, ar_last_q);
                end
            end
            AR_GRANT: begin
                if (BUS_RD_ADDR_VALID && BUS_RD_ADDR_READY) begin
                    ar_state_d = AR_IDLE;
                    ar_last_d  = rd_addr_sel_q;
                end
            end
        endcase
    end

    always_comb begin
        wq_pop     = BUS_WR_DATA_VALID && BUS_WR_DATA_READY &&
                     BUS_WR_DATA_LAST && !wr_data_gate;
        wq_wptr_d  = wq_wptr_q + PW'(wq_push);
        wq_rptr_d  = wq_rptr_q + PW'(wq_pop);
        wq_count_d = wq_count_q + CW'(wq_push) - CW'(wq_pop);
        wq_remain  = wq_count_q - CW'(wq_pop);
        wr_data_sel_d = wr_data_sel_q;
        // A push into an empty queue bypasses the memory so the head shows next cycle
        if (wq_remain != '0) begin
            wr_data_sel_d = wq_mem_q[wq_rptr_d];
        end else if (wq_push) begin
            wr_data_sel_d = wr_addr_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_state_q    <= AW_IDLE;
            ar_state_q    <= AR_IDLE;
            wr_addr_sel_q <= '0;
            rd_addr_sel_q <= '0;
            aw_last_q     <= '1;
            ar_last_q     <= '1;
            wr_data_sel_q <= '0;
            wq_wptr_q     <= '0;
            wq_rptr_q     <= '0;
            wq_count_q    <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) begin
                wq_mem_q[i] <= '0;
            end
        end else begin
            aw_state_q    <= aw_state_d;
            ar_state_q    <= ar_state_d;
            wr_addr_sel_q <= wr_addr_sel_d;
            rd_addr_sel_q <= rd_addr_sel_d;
            aw_last_q     <= aw_last_d;
            ar_last_q     <= ar_last_d;
            wr_data_sel_q <= wr_data_sel_d;
            wq_wptr_q     <= wq_wptr_d;
            wq_rptr_q     <= wq_rptr_d;
            wq_count_q    <= wq_count_d;
            if (wq_push) begin
                wq_mem_q[wq_wptr_q] <= wr_addr_sel_q;
            end
        end
    end

    logic unused_id_bits;
    assign unused_id_bits = ^{BUS_WR_BACK_ID[M_ID-1:0], BUS_RD_BACK_ID[M_ID-1:0]};

    assign wr_addr_sel  = wr_addr_sel_q;
    assign rd_addr_sel  = rd_addr_sel_q;
    assign wr_data_sel  = wr_data_sel_q;
    assign wr_data_gate = (wq_count_q == '0);
    assign wq_full      = (wq_count_q == CW'(WQ_DEPTH));
    assign wr_resp_sel  = BUS_WR_BACK_ID[M_ID+M_WIDTH-1:M_ID];
    assign rd_data_sel  = BUS_RD_BACK_ID[M_ID+M_WIDTH-1:M_ID];

endmodule
